// File: rtl/fifo_pack_pkg.sv
// fifo_pack_pkg: shared byte width, lane-count type and keep-mask helper for the FIFO read packer
package fifo_pack_pkg;

    localparam int BYTE_W    = 8;
    localparam int MAX_BYTES = 8;

    typedef logic [3:0] cnt_t;

    function automatic logic [MAX_BYTES-1:0] keep_mask(input cnt_t n);
        keep_mask = '0;
        for (int i = 0; i < MAX_BYTES; i++)
            keep_mask[i] = cnt_t'(i) < n;
    endfunction

endpackage

// File: rtl/fifo_pack_timer.sv
// fifo_pack_timer: idle counter that saturates at TIMEOUT_CYC and flags terminal count
module fifo_pack_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    input  logic tick,
    output logic tc
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] count;

    assign tc = count == W'(TIMEOUT_CYC);

    // Holding at terminal count lets a timeout wait for a busy output slot
    always_ff @(posedge clock or negedge reset)
        if (!reset)
            count <= '0;
        else if (restart)
            count <= '0;
        else if (tick && !tc)
            count <= count + W'(1);

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops FIFO bytes and packs BYTES of them per word on a valid/ready stream
// Partial-word timeout flush is built only when FIFO_PACK_FLUSH_EN is defined.
module fifo_rd_packer
    import fifo_pack_pkg::*;
#(
    parameter int DATA_W      = BYTE_W,
    parameter int BYTES       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       fifo_data,
    input  logic                    fifo_empty,
    output logic                    fifo_pop,
    output logic [BYTES*DATA_W-1:0] word_out,
    output logic [BYTES-1:0]        word_keep,
    output logic                    word_valid,
    input  logic                    word_ready
);

    logic [BYTES-1:0][DATA_W-1:0] lanes;
    cnt_t                         cnt;
    logic                         rd_pend;
    logic                         run;
    logic                         slot_free;
    logic                         full;
    logic                         flush;
    logic                         load;
    logic [BYTES-1:0]             load_keep;

    assign slot_free = !word_valid || word_ready;
    assign full      = cnt == cnt_t'(BYTES);
    // Counting the in-flight byte keeps pops from ever overrunning the lanes
    assign fifo_pop  = run && !fifo_empty && ((cnt + cnt_t'(rd_pend)) < cnt_t'(BYTES));
    assign load      = (full || flush) && slot_free;

`ifdef FIFO_PACK_FLUSH_EN
    logic tc;

    fifo_pack_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .restart(rd_pend || cnt == '0),
        .tick   (!rd_pend && !fifo_pop),
        .tc     (tc)
    );

    assign flush     = tc && cnt != '0 && !rd_pend && !fifo_pop;
    assign load_keep = BYTES'(keep_mask(cnt));
`else
    assign flush     = 1'b0;
    assign load_keep = '1;
`endif

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            lanes      <= '0;
            cnt        <= '0;
            rd_pend    <= 1'b0;
            run        <= 1'b0;
            word_out   <= '0;
            word_keep  <= '0;
            word_valid <= 1'b0;
        end else begin
            run     <= 1'b1;
            rd_pend <= fifo_pop;
            if (word_valid && word_ready)
                word_valid <= 1'b0;
            if (load) begin
                word_out   <= lanes;
                word_keep  <= load_keep;
                word_valid <= 1'b1;
                cnt        <= '0;
                lanes      <= '0;
            end else if (rd_pend) begin
                for (int i = 0; i < BYTES; i++)
                    if (cnt == cnt_t'(i))
                        lanes[i] <= fifo_data;
                cnt <= cnt + cnt_t'(1);
            end
        end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed and random checks of the read packer against a FIFO/stream model
// Flush-timeout checks are selected by FIFO_PACK_FLUSH_EN.
module tb_fifo_rd_packer;

    localparam int BYTES = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_empty = 1'b1;
    logic        fifo_pop;
    logic [31:0] word_out;
    logic [3:0]  word_keep;
    logic        word_valid;
    logic        word_ready = 1'b0;

    logic [7:0]  q[$];
    logic [7:0]  sb[$];
    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    int          words = 0;
    int          cyc = 0;
    int          p20, p2, vc, nv;
    bit          rnd = 1'b0;
    bit          hold = 1'b0;
    bit          pop_s, hs;
    logic [31:0] w_s, last_w, vw;
    logic [3:0]  k_s, last_k, vk;

    fifo_rd_packer #(
        .DATA_W     (8),
        .BYTES      (BYTES),
        .TIMEOUT_CYC(16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_pop  (fifo_pop),
        .word_out  (word_out),
        .word_keep (word_keep),
        .word_valid(word_valid),
        .word_ready(word_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        sb.push_back(b);
        fifo_empty = hold || q.size() == 0;
    endtask

    // Each emitted word must be the next bytes of the pushed stream, first byte in lane 0
    task automatic score();
        int          n;
        logic [31:0] ew;
        logic [3:0]  ek;
`ifdef FIFO_PACK_FLUSH_EN
        n = $countones(k_s);
        check("keep_nonzero", n != 0, 1);
`else
        n = BYTES;
`endif
        ek = 4'((1 << n) - 1);
        ew = '0;
        check("stream_left", sb.size() >= n, 1);
        for (int i = 0; i < n; i++)
            if (sb.size() > 0)
                ew[i*8 +: 8] = sb.pop_front();
        check("word", w_s, ew);
        check("keep", k_s, ek);
        words++;
        last_w = w_s;
        last_k = k_s;
    endtask

    task automatic tick();
        @(negedge clock);
        pop_s = fifo_pop;
        hs    = word_valid && word_ready;
        w_s   = word_out;
        k_s   = word_keep;
        if (pop_s)
            check("pop_while_empty", fifo_empty, 0);
        @(posedge clock);
        #1;
        cyc++;
        if (pop_s && q.size() > 0) begin
            fifo_data = q.pop_front();
            pops++;
        end
        if (hs)
            score();
        if (rnd) begin
            word_ready = 1'($urandom_range(0, 1));
            hold       = $urandom_range(0, 2) == 0;
        end
        fifo_empty = hold || q.size() == 0;
    endtask

    initial begin
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (5) begin
            tick();
            check("rst_pop", pop_s, 0);
            check("rst_valid", word_valid, 0);
            check("rst_out", word_out, 0);
            check("rst_keep", word_keep, 0);
        end
        reset = 1'b1;
        tick();
        check("pop_first_edge", pop_s, 0);
        tick();
        check("pop_after_release", pop_s, 1);
        word_ready = 1'b1;
        for (int i = 0; i < 40 && words < 1; i++) tick();
        check("t2_words", words, 1);
        check("t2_word", last_w, 32'h44332211);
        check("t2_keep", last_k, 4'hF);
        repeat (10) tick();
        check("t2_pops", pops, 4);
        check("t2_no_extra_word", words, 1);
        check("t2_valid_drop", word_valid, 0);

        word_ready = 1'b0;
        pops = 0;
        words = 0;
        p20 = 0;
        for (int i = 1; i <= 12; i++) push(8'(i));
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 20) p20 = pops;
            if (word_valid) check("t3_hold", word_out, 32'h04030201);
        end
        check("t3_pops", pops, 8);
        check("t3_stall", pops, p20);
        check("t3_valid", word_valid, 1);
        check("t3_pop_low", fifo_pop, 0);
        word_ready = 1'b1;
        for (int i = 0; i < 60 && words < 3; i++) tick();
        check("t3_words", words, 3);
        check("t3_last", last_w, 32'h0C0B0A09);

        words = 0;
        pops = 0;
        push(8'h97); push(8'h98); push(8'h99);
        for (int i = 0; i < 20 && pops < 3; i++) tick();
        tick();
        tick();
        check("t5_no_word", words, 0);
        check("t5_valid_low", word_valid, 0);
        reset = 1'b0;
        sb.delete();
        push(8'h55); push(8'h56); push(8'h57); push(8'h58);
        #1;
        check("t5_pop_in_reset", fifo_pop, 0);
        tick();
        tick();
        check("t5_pops_in_reset", pops, 3);
        reset = 1'b1;
        for (int i = 0; i < 40 && words < 1; i++) tick();
        repeat (10) tick();
        check("t5_words", words, 1);
        check("t5_word", last_w, 32'h58575655);
        check("t5_pops", pops, 7);

        words = 0;
        pops = 0;
        p2 = -1;
        vc = -1;
        nv = 0;
        push(8'hAA); push(8'hBB);
`ifdef FIFO_PACK_FLUSH_EN
        for (int i = 0; i < 40 && vc < 0; i++) begin
            tick();
            if (pops == 2 && p2 < 0) p2 = cyc;
            if (word_valid && vc < 0) begin
                vc = cyc;
                vw = word_out;
                vk = word_keep;
            end
        end
        check("t4_flush_seen", vc >= 0, 1);
        check("t4_delay_min", vc - p2 >= 17, 1);
        check("t4_delay_max", vc - p2 <= 19, 1);
        check("t4_word", vw, 32'h0000BBAA);
        check("t4_keep", vk, 4'b0011);
        repeat (3) tick();
`else
        repeat (100) begin
            tick();
            if (word_valid) nv++;
        end
        check("t4_no_word", nv, 0);
        check("t4_pops", pops, 2);
`endif

        for (int i = 0; i < 1000; i++) push(8'($urandom_range(0, 255)));
        while (sb.size() % BYTES != 0) push(8'($urandom_range(0, 255)));
        rnd = 1'b1;
        for (int i = 0; i < 20000 && (sb.size() > 0 || q.size() > 0); i++) tick();
        rnd = 1'b0;
        hold = 1'b0;
        word_ready = 1'b1;
        repeat (30) tick();
        check("t6_drained", sb.size(), 0);
        check("t6_fifo_empty", q.size(), 0);
        check("t6_valid_low", word_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
